// File: rtl/ddr_data_in.sv
// ddr_data_in: receive side of the I/Q DDR link.
// The IDDR cells deliver a rising-edge and a falling-edge half-word per clk
// cycle, plus the forwarded clock sampled on both edges. This block registers
// them, locks onto the forwarded-clock pattern (normal 10 or half-cycle-swapped
// 01), pairs half-words into I/Q samples and queues them in a small
// first-word-fall-through FIFO behind a valid/ready interface.
//
// Pipeline (FIFO empty, locked):
//   cycle n   : pins
//   cycle n+1 : stage-1 registers, pattern check, pairing, push decision
//   cycle n+2 : push stage, FIFO write at the end of the cycle
//   cycle n+3 : sample visible on out_i/out_q with out_valid
module ddr_data_in #(
    parameter int LOCK_COUNT = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rx_rise,
    input  logic [15:0] rx_fall,
    input  logic        rx_clk_rise,
    input  logic        rx_clk_fall,
    input  logic        enable,
    input  logic        clear,
    output logic [15:0] out_i,
    output logic [15:0] out_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        locked,
    output logic        swapped,
    output logic        overflow,
    output logic [15:0] err_count
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0]       LOCK_TARGET   = 8'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO      = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE       = PTR_W'(1);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [1:0] PAT_NORMAL  = 2'b10;
    localparam logic [1:0] PAT_SWAPPED = 2'b01;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Only 10 and 01 are legal forwarded-clock patterns; 00/11 mean a
    // missing or stuck edge.
    function automatic logic patIsValid(input logic [1:0] pat);
        return (pat == PAT_NORMAL) || (pat == PAT_SWAPPED);
    endfunction

    // Run-length counter used while searching: counts consecutive identical
    // valid patterns, restarts at 1 on a new valid pattern, zero on invalid.
    function automatic logic [7:0] lockCntStep(input logic [1:0] pat,
                                               input logic [1:0] prevPat,
                                               input logic [7:0] cnt);
        logic [7:0] nextCnt;
        if (!patIsValid(pat)) begin
            nextCnt = 8'd0;
        end else if (pat == prevPat) begin
            nextCnt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end else begin
            nextCnt = 8'd1;
        end
        return nextCnt;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: capture registers
    // ------------------------------------------------------------------
    logic [15:0] riseD_r;
    logic [15:0] fallD_r;
    logic [15:0] prevFall_r;
    logic        clkRiseD_r;
    logic        clkFallD_r;

    // Register the IDDR outputs and keep one extra falling half-word for the
    // swapped pairing.
    always_ff @(posedge clk) begin
        if (rst) begin
            riseD_r    <= 16'h0000;
            fallD_r    <= 16'h0000;
            prevFall_r <= 16'h0000;
            clkRiseD_r <= 1'b0;
            clkFallD_r <= 1'b0;
        end else begin
            riseD_r    <= rx_rise;
            fallD_r    <= rx_fall;
            prevFall_r <= fallD_r;
            clkRiseD_r <= rx_clk_rise;
            clkFallD_r <= rx_clk_fall;
        end
    end

    // ------------------------------------------------------------------
    // Alignment FSM
    // ------------------------------------------------------------------
    logic [0:0] state_r;
    logic [7:0] lockCnt_r;
    logic [1:0] prevPat_r;
    logic       swapped_r;
    logic       locked_r;

    logic [1:0] pat_s;
    logic [1:0] lockPat_s;
    logic [0:0] stateNext_s;
    logic [7:0] lockCntNext_s;
    logic       swappedNext_s;
    logic       lossEvent_s;

    assign pat_s     = {clkRiseD_r, clkFallD_r};
    // The latched pattern is fully described by the swapped flag.
    assign lockPat_s = swapped_r ? PAT_SWAPPED : PAT_NORMAL;

    // Next-state logic: search for a stable pattern, drop lock on any deviation.
    always_comb begin
        stateNext_s   = state_r;
        lockCntNext_s = lockCnt_r;
        swappedNext_s = swapped_r;
        lossEvent_s   = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                lockCntNext_s = lockCntStep(pat_s, prevPat_r, lockCnt_r);
                if (lockCntNext_s == LOCK_TARGET) begin
                    stateNext_s   = ST_LOCKED;
                    swappedNext_s = (pat_s == PAT_SWAPPED);
                    lockCntNext_s = 8'd0;
                end else begin
                    stateNext_s   = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (pat_s != lockPat_s) begin
                    stateNext_s   = ST_SEARCH;
                    lockCntNext_s = 8'd0;
                    lossEvent_s   = 1'b1;
                end else begin
                    stateNext_s   = ST_LOCKED;
                    lockCntNext_s = 8'd0;
                end
            end
            default: begin
                stateNext_s   = ST_SEARCH;
                lockCntNext_s = 8'd0;
            end
        endcase
    end

    // FSM state, run-length counter, previous pattern and lock/swap flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_SEARCH;
            lockCnt_r <= 8'd0;
            prevPat_r <= 2'b00;
            swapped_r <= 1'b0;
            locked_r  <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            lockCnt_r <= lockCntNext_s;
            prevPat_r <= pat_s;
            swapped_r <= swappedNext_s;
            locked_r  <= (stateNext_s == ST_LOCKED);
        end
    end

    // ------------------------------------------------------------------
    // Pairing and push stage
    // ------------------------------------------------------------------
    logic        pushReq_s;
    logic [15:0] pairI_s;
    logic [15:0] pairQ_s;

    logic        pushVld_r;
    logic [15:0] pushI_r;
    logic [15:0] pushQ_r;

    // A pair is only trusted while locked and the current pattern agrees.
    assign pushReq_s = (state_r == ST_LOCKED) && (pat_s == lockPat_s) && enable;

    // Swapped link: the falling half-word of the previous cycle is the I
    // half of the sample whose Q half arrives on this cycle's rising edge.
    always_comb begin
        pairI_s = riseD_r;
        pairQ_s = fallD_r;
        if (swapped_r) begin
            pairI_s = prevFall_r;
            pairQ_s = riseD_r;
        end else begin
            pairI_s = riseD_r;
            pairQ_s = fallD_r;
        end
    end

    // Hold the accepted pair for one cycle in front of the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            pushVld_r <= 1'b0;
            pushI_r   <= 16'h0000;
            pushQ_r   <= 16'h0000;
        end else begin
            pushVld_r <= pushReq_s;
            pushI_r   <= pairI_s;
            pushQ_r   <= pairQ_s;
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO with registered head
    // ------------------------------------------------------------------
    logic [15:0]      memI [FIFO_DEPTH];
    logic [15:0]      memQ [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [CNT_W-1:0] count_r;
    logic             outValid_r;
    logic [15:0]      outI_r;
    logic [15:0]      outQ_r;

    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             ovfEvent_s;
    logic [PTR_W-1:0] rdPtrNext_s;
    logic [PTR_W-1:0] wrPtrNext_s;
    logic [CNT_W-1:0] countNext_s;
    logic [15:0]      headI_s;
    logic [15:0]      headQ_s;

    assign full_s     = (count_r == FIFO_FULL_CNT);
    assign pop_s      = outValid_r && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_s     = pushVld_r && (!full_s || pop_s);
    assign ovfEvent_s = pushVld_r && full_s && !pop_s;

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_comb begin
        rdPtrNext_s = rdPtr_r;
        wrPtrNext_s = wrPtr_r;
        countNext_s = count_r;
        if (pop_s) begin
            rdPtrNext_s = rdPtr_r + PTR_ONE;
        end else begin
            rdPtrNext_s = rdPtr_r;
        end
        if (push_s) begin
            wrPtrNext_s = wrPtr_r + PTR_ONE;
        end else begin
            wrPtrNext_s = wrPtr_r;
        end
        case ({push_s, pop_s})
            2'b10:   countNext_s = count_r + CNT_ONE;
            2'b01:   countNext_s = count_r - CNT_ONE;
            default: countNext_s = count_r;
        endcase
    end

    // Next head: the entry being written this cycle if it lands at the new
    // read position, otherwise what is already stored there.
    always_comb begin
        headI_s = 16'h0000;
        headQ_s = 16'h0000;
        if (countNext_s == CNT_ZERO) begin
            headI_s = 16'h0000;
            headQ_s = 16'h0000;
        end else if (push_s && (wrPtr_r == rdPtrNext_s)) begin
            headI_s = pushI_r;
            headQ_s = pushQ_r;
        end else begin
            headI_s = memI[rdPtrNext_s];
            headQ_s = memQ[rdPtrNext_s];
        end
    end

    // Storage array; contents are meaningless while not counted as occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            memI[wrPtr_r] <= pushI_r;
            memQ[wrPtr_r] <= pushQ_r;
        end
    end

    // Pointers, occupancy and the registered head view.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_r    <= PTR_ZERO;
            rdPtr_r    <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            outValid_r <= 1'b0;
            outI_r     <= 16'h0000;
            outQ_r     <= 16'h0000;
        end else begin
            wrPtr_r    <= wrPtrNext_s;
            rdPtr_r    <= rdPtrNext_s;
            count_r    <= countNext_s;
            outValid_r <= (countNext_s != CNT_ZERO);
            outI_r     <= headI_s;
            outQ_r     <= headQ_s;
        end
    end

    // ------------------------------------------------------------------
    // Status: sticky overflow and saturating lock-loss counter
    // ------------------------------------------------------------------
    logic        overflow_r;
    logic [15:0] errCount_r;

    // clear takes priority over a coinciding overflow or lock-loss event.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
            errCount_r <= 16'h0000;
        end else if (clear) begin
            overflow_r <= 1'b0;
            errCount_r <= 16'h0000;
        end else begin
            if (ovfEvent_s) begin
                overflow_r <= 1'b1;
            end
            if (lossEvent_s && (errCount_r != 16'hFFFF)) begin
                errCount_r <= errCount_r + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_i     = outI_r;
    assign out_q     = outQ_r;
    assign out_valid = outValid_r;
    assign locked    = locked_r;
    assign swapped   = swapped_r;
    assign overflow  = overflow_r;
    assign err_count = errCount_r;

endmodule
